// File: rtl/vppm_pkg.sv
// Shared VPPM definitions: frame FSM states and the symbol timing defaults
// used by both the transmitter and the receive chain.
`timescale 1ns/1ps
package vppm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam int         NBITS_DEF     = 16;
  localparam int         PERIOD_DEF    = 100;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         BYTE_BITS     = 8;

endpackage

// File: rtl/vppm_symbol_gen.sv
// VPPM symbol timing: free-running period counter, duty clamp/latch and the
// pulse compare that shapes one symbol for the bit requested by the frame FSM.
`timescale 1ns/1ps
module vppm_symbol_gen
  import vppm_pkg::*;
#(
  parameter int NBITS  = NBITS_DEF,
  parameter int PERIOD = PERIOD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NBITS-1:0] duty,
  input  logic             cur_bit_req,
  input  logic             pulse_en,
  output logic             boundary,
  output logic             vppm_out,
  output logic             sym_strobe
);

  localparam logic [NBITS-1:0] LAST     = NBITS'(PERIOD - 1);
  localparam logic [NBITS:0]   PERIOD_W = (NBITS + 1)'(PERIOD);

  logic [NBITS-1:0] cnt;
  logic [NBITS-1:0] duty_q;
  logic             cur_bit_q;
  logic             sym_start;
  logic [NBITS-1:0] duty_clamped;
  logic [NBITS-1:0] duty_eff;
  logic             bit_eff;
  logic [NBITS:0]   cnt_w;
  logic [NBITS:0]   duty_w;
  logic             pulse;

  assign sym_start = (cnt == '0);
  assign boundary  = (cnt == LAST);

  always_comb begin
    duty_clamped = duty;
    if (duty == '0) begin
      duty_clamped = NBITS'(1);
    end else if ({1'b0, duty} >= PERIOD_W) begin
      duty_clamped = LAST;
    end
  end

  // On the first clock of a symbol the freshly clamped duty and requested bit
  // are used directly, so the compare needs no extra cycle of latency.
  assign duty_eff = sym_start ? duty_clamped : duty_q;
  assign bit_eff  = sym_start ? cur_bit_req  : cur_bit_q;

  always_comb begin
    cnt_w  = {1'b0, cnt};
    duty_w = {1'b0, duty_eff};
    pulse  = bit_eff ? (cnt_w >= (PERIOD_W - duty_w)) : (cnt_w < duty_w);
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      duty_q     <= '0;
      cur_bit_q  <= 1'b0;
      vppm_out   <= 1'b0;
      sym_strobe <= 1'b0;
    end else begin
      cnt        <= boundary ? '0 : cnt + NBITS'(1);
      if (sym_start) begin
        duty_q    <= duty_clamped;
        cur_bit_q <= cur_bit_req;
      end
      vppm_out   <= pulse & pulse_en;
      sym_strobe <= sym_start;
    end
  end

endmodule

// File: rtl/vppm_tx.sv
// VPPM transmitter: one-byte holding buffer, sync-prefixed frame FSM and
// MSB-first serializer driving the symbol generator.
`timescale 1ns/1ps
module vppm_tx
  import vppm_pkg::*;
#(
  parameter int         NBITS     = NBITS_DEF,
  parameter int         PERIOD    = PERIOD_DEF,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter bit         IDLE_DIM  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] duty,
  output logic             vppm_out,
  output logic             sym_strobe,
  output logic             busy
);

  localparam logic [2:0] LAST_BIT = 3'(BYTE_BITS - 1);

  state_t     state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] buf_q, buf_d;
  logic       buf_full_q, buf_full_d;
  logic       accept;
  logic       load;
  logic       boundary;
  logic       cur_bit_req;
  logic       pulse_en;

  assign accept      = in_valid & in_ready;
  assign busy        = (state_q != IDLE);
  assign cur_bit_req = (state_q == IDLE) ? 1'b0 : shreg_q[7];
  assign pulse_en    = IDLE_DIM | (state_q != IDLE);

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    load       = 1'b0;

    if (boundary) begin
      unique case (state_q)
        IDLE: begin
          if (buf_full_q) begin
            state_d  = SYNC;
            shreg_d  = SYNC_BYTE;
            bitcnt_d = '0;
          end
        end
        SYNC, DATA: begin
          if (bitcnt_q == LAST_BIT) begin
            if (buf_full_q) begin
              state_d  = DATA;
              shreg_d  = buf_q;
              bitcnt_d = '0;
              load     = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            shreg_d  = {shreg_q[6:0], 1'b0};
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A new byte wins over a load so the buffer stays full when both happen.
    if (accept) begin
      buf_d      = in_data;
      buf_full_d = 1'b1;
    end else if (load) begin
      buf_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
      buf_full_q <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
      buf_full_q <= buf_full_d;
      in_ready   <= ~buf_full_d;
    end
  end

  // NOTE: the buffer data needs no reset; buf_full_q alone decides whether
  // its contents are ever used.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  vppm_symbol_gen #(
    .NBITS  (NBITS),
    .PERIOD (PERIOD)
  ) u_symbol_gen (
    .clk         (clk),
    .rst         (rst),
    .duty        (duty),
    .cur_bit_req (cur_bit_req),
    .pulse_en    (pulse_en),
    .boundary    (boundary),
    .vppm_out    (vppm_out),
    .sym_strobe  (sym_strobe)
  );

endmodule

// File: tb/tb_vppm_tx.sv
// Self-checking bench for vppm_tx: duty table sweep, scoreboarded frames,
// back-to-back bytes, mid-frame reset and the IDLE_DIM=0 variant.
`timescale 1ns/1ps
module tb_vppm_tx;
  import vppm_pkg::*;

  localparam int P  = 100;
  localparam int NB = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    in_data, in_data0;
  logic          in_valid, in_valid0;
  logic          in_ready, in_ready0;
  logic [NB-1:0] duty;
  logic          vppm_out, vppm_out0;
  logic          sym_strobe, sym_strobe0;
  logic          busy, busy0;

  always #5 clk = ~clk;

  vppm_tx #(.NBITS(NB), .PERIOD(P), .SYNC_BYTE(SYNC_BYTE_DEF), .IDLE_DIM(1'b1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .duty(duty), .vppm_out(vppm_out), .sym_strobe(sym_strobe), .busy(busy)
  );

  vppm_tx #(.NBITS(NB), .PERIOD(P), .SYNC_BYTE(SYNC_BYTE_DEF), .IDLE_DIM(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
    .duty(duty), .vppm_out(vppm_out0), .sym_strobe(sym_strobe0), .busy(busy0)
  );

  typedef struct {
    logic [NB-1:0] duty;
    int            width;
  } duty_vec_t;

  duty_vec_t tab[8];
  int        checks = 0;
  int        errors = 0;
  logic      exp_q[$];
  int        mon_nb, mon_bc;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [P-1:0] exp_wave(input logic b, input int width);
    logic [P-1:0] w;
    for (int k = 0; k < P; k++) w[k] = b ? (k >= P - width) : (k < width);
    return w;
  endfunction

  task automatic wait_strobe();
    int n = 0;
    do begin @(negedge clk); n++; end while (!sym_strobe && n < 300);
    check("strobe_seen", sym_strobe, 1'b1);
  endtask

  // Records one whole symbol from its strobe; optionally changes duty mid-symbol.
  task automatic capture(input int chg_at, input logic [NB-1:0] chg_val,
                         output logic [P-1:0] wave, output logic b0,
                         output int bclks, output int wait_n, output int extra);
    wave = '0; b0 = 1'b0; bclks = 0; wait_n = 0; extra = 0;
    do begin @(negedge clk); wait_n++; end while (!sym_strobe && wait_n < 300);
    check("strobe_seen", sym_strobe, 1'b1);
    if (sym_strobe) begin
      wave[0] = vppm_out;
      b0      = busy;
      bclks   = int'(busy);
      for (int k = 1; k < P; k++) begin
        @(negedge clk);
        if (k == chg_at) duty = chg_val;
        wave[k] = vppm_out;
        bclks  += int'(busy);
        extra  += int'(sym_strobe);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit first, input bit keep);
    int n = 0;
    logic [7:0] sb = SYNC_BYTE_DEF;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 3000) begin @(negedge clk); n++; end
    check("accept_ready", in_ready, 1'b1);
    if (in_ready) begin
      if (first) for (int i = 7; i >= 0; i--) exp_q.push_back(sb[i]);
      for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
      @(negedge clk);
      check("ready_drop", in_ready, 1'b0);
    end
    if (!keep) in_valid = 1'b0;
  endtask

  // Captures contiguous symbols until a frame has come and gone.
  task automatic frame_monitor(input int wdt, output int nb, output int bc);
    logic [P-1:0] w;
    logic         b0, eb;
    int           bcl, wn, ex;
    nb = 0; bc = 0;
    for (int s = 0; s < 40; s++) begin
      capture(-1, '0, w, b0, bcl, wn, ex);
      bc += bcl;
      if (s > 0) check("sym_contig", wn, 1);
      check("strobe_once", ex, 0);
      if (b0) begin
        nb++;
        check("sb_depth", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          eb = exp_q.pop_front();
          check("frame_sym", w, exp_wave(eb, wdt));
        end
      end else begin
        check("idle_sym", w, exp_wave(1'b0, wdt));
        if (nb > 0) break;
      end
    end
  endtask

  initial begin
    logic [P-1:0] w;
    logic         b0;
    int           bcl, wn, ex, prev, ns, t, highs, bcnt;

    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_data0 = '0; in_valid0 = 1'b0;
    duty = NB'(30);
    tab[0] = '{NB'(0),     1};
    tab[1] = '{NB'(150),  99};
    tab[2] = '{NB'(99),   99};
    tab[3] = '{NB'(100),  99};
    tab[4] = '{NB'(1),     1};
    tab[5] = '{NB'(65535), 99};
    tab[6] = '{NB'(2),     2};
    tab[7] = '{NB'(30),   30};

    repeat (3) @(negedge clk);
    check("rst_vppm", vppm_out, 1'b0);
    check("rst_strobe", sym_strobe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", in_ready, 1'b0);
    check("rst_vppm0", vppm_out0, 1'b0);
    rst = 1'b0;

    // Idle duty sweep: each entry is applied at cnt~50 and shows up one symbol later.
    prev = 30;
    for (int i = 0; i < 8; i++) begin
      capture(50, tab[i].duty, w, b0, bcl, wn, ex);
      check("duty_wave", w, exp_wave(1'b0, prev));
      check("idle_busy", b0, 1'b0);
      check("strobe_once", ex, 0);
      if (i > 0) check("strobe_period", wn, 1);
      prev = tab[i].width;
    end
    capture(-1, '0, w, b0, bcl, wn, ex);
    check("duty_wave", w, exp_wave(1'b0, prev));
    check("ready_idle", in_ready, 1'b1);

    // Single byte frame: A5 then 3C.
    fork
      frame_monitor(30, mon_nb, mon_bc);
      begin wait_strobe(); send_byte(8'h3C, 1'b1, 1'b0); end
    join
    check("frame_syms", mon_nb, 16);
    check("busy_clks", mon_bc, 1600);
    check("sb_empty", exp_q.size(), 0);

    // Back-to-back bytes with in_valid held high.
    fork
      frame_monitor(30, mon_nb, mon_bc);
      begin wait_strobe(); send_byte(8'h00, 1'b1, 1'b1); send_byte(8'hFF, 1'b0, 1'b0); end
    join
    check("b2b_syms", mon_nb, 24);
    check("b2b_busy_clks", mon_bc, 2400);
    check("sb_empty", exp_q.size(), 0);

    // Reset at cnt~40 of the first DATA symbol while a second byte is pending.
    duty = NB'(60);
    fork
      begin wait_strobe(); send_byte(8'h3C, 1'b1, 1'b0); send_byte(8'h55, 1'b0, 1'b0); end
      begin
        ns = 0; t = 0;
        while (ns < 9 && t < 5000) begin
          @(negedge clk); t++;
          if (sym_strobe && busy) ns++;
        end
        check("reach_data", ns, 9);
        repeat (40) @(negedge clk);
        check("pre_rst_high", vppm_out, 1'b1);
        check("pre_rst_busy", busy, 1'b1);
      end
    join
    rst = 1'b1;
    @(negedge clk);
    check("abort_vppm", vppm_out, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_ready", in_ready, 1'b0);
    check("abort_strobe", sym_strobe, 1'b0);
    rst = 1'b0;
    exp_q.delete();
    capture(-1, '0, w, b0, bcl, wn, ex);
    check("post_rst_first", wn, 1);
    check("post_rst_wave", w, exp_wave(1'b0, 60));
    check("post_rst_busy", b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      capture(-1, '0, w, b0, bcl, wn, ex);
      check("no_pending_tx", bcl, 0);
      check("post_rst_wave", w, exp_wave(1'b0, 60));
    end
    check("post_rst_ready", in_ready, 1'b1);

    // IDLE_DIM=0 instance: dark while idle, 16 symbols of 30 clocks in a frame.
    duty = NB'(30);
    highs = 0;
    repeat (200) begin @(negedge clk); highs += int'(vppm_out0); end
    check("dark_idle", highs, 0);
    in_data0 = 8'h81; in_valid0 = 1'b1; t = 0;
    while (!in_ready0 && t < 300) begin @(negedge clk); t++; end
    check("accept_ready0", in_ready0, 1'b1);
    @(negedge clk);
    in_valid0 = 1'b0;
    highs = 0; bcnt = 0;
    repeat (1900) begin
      @(negedge clk);
      highs += int'(vppm_out0);
      bcnt  += int'(busy0);
    end
    check("dark_frame_high", highs, 480);
    check("dark_frame_busy", bcnt, 1600);
    check("dark_end_busy", busy0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
